// File: rtl/dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl
//
// MEM-stage data-memory access controller. Sits directly behind the
// store/load alignment wrapper. It takes the aligned store word and byte mask
// and runs one valid/ack bus transaction at a time. It holds the pipeline
// while that transaction is in flight. It returns the raw memory word and the
// latched byte offset, which the wrapper uses as its load input and byte
// address.
//
// Optional feature (macro MISALIGN_TRAP_EN):
//   defined   - misaligned half/word requests skip the bus and complete
//               immediately with rsp_misalign=1 and rsp_rdata=0.
//   undefined - every request goes to the bus; rsp_misalign is always 0.
//
// Parameters:
//   TIMEOUT - maximum ISSUE cycles without mem_ack before the access is
//             aborted with rsp_err. A value of 0 disables the timeout.
//   AW      - address width.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   req_*                     MEM-stage request (valid, we, size, addr,
//                             wdata, mask)
//   stall                     holds the pipeline while a request is pending
//   mem_req/we/addr/wdata/wstrb
//                             bus request, held stable until mem_ack
//   mem_ack, mem_rdata        bus completion and read data
//   rsp_valid                 one-cycle completion pulse
//   rsp_rdata, rsp_byteadd, rsp_err, rsp_misalign
//                             completion payload; these hold until the next
//                             capture
// ---------------------------------------------------------------------------
module dmem_access_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    input  logic [3:0]    req_mask,
    output logic          stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic [1:0]    rsp_byteadd,
    output logic          rsp_err,
    output logic          rsp_misalign
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AW-3:0]   waddr_q, waddr_d;   // word address; the byte offset lives in byteadd_q
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      mask_q, mask_d;
    logic            req_q, req_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [1:0]      byteadd_q, byteadd_d;
    logic            err_q, err_d;
    logic            mis_q, mis_d;

    logic            misalign;
    logic            timeout_hit;

`ifdef MISALIGN_TRAP_EN
    // Bytes are never misaligned. A half is misaligned only when it would
    // cross the word boundary. Word and reserved sizes must be word aligned.
    always_comb begin
        misalign = 1'b0;
        case (req_size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = (req_addr[1:0] == 2'b11);
            default: misalign = (req_addr[1:0] != 2'b00);
        endcase
    end
`else
    logic unused_req_size;
    assign unused_req_size = ^req_size;
    assign misalign        = 1'b0;
`endif

    generate
        if (TIMEOUT > 0) begin : g_timeout
            assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        mask_d    = mask_q;
        req_d     = req_q;
        rdata_d   = rdata_q;
        byteadd_d = byteadd_q;
        err_d     = err_q;
        mis_d     = mis_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d      = req_we;
                    waddr_d   = req_addr[AW-1:2];
                    wdata_d   = req_wdata;
                    mask_d    = req_we ? req_mask : 4'b0000;
                    byteadd_d = req_addr[1:0];
                    cnt_d     = '0;
                    if (misalign) begin
                        // Trap without touching the bus.
                        state_d = DONE;
                        rdata_d = 32'h0;
                        err_d   = 1'b0;
                        mis_d   = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        req_d   = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (mem_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    rdata_d = we_q ? 32'h0 : mem_rdata;
                    err_d   = 1'b0;
                    mis_d   = 1'b0;
                end else if (timeout_hit) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    mis_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                // A new request is never accepted here. That gives the
                // pipeline exactly one advance per access.
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= 32'h0;
            mask_q    <= 4'b0000;
            req_q     <= 1'b0;
            rdata_q   <= 32'h0;
            byteadd_q <= 2'b00;
            err_q     <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            mask_q    <= mask_d;
            req_q     <= req_d;
            rdata_q   <= rdata_d;
            byteadd_q <= byteadd_d;
            err_q     <= err_d;
            mis_q     <= mis_d;
        end
    end

    // The bus outputs are qualified by mem_req. The bus therefore sees zeros
    // whenever no transaction is outstanding.
    assign mem_req      = req_q;
    assign mem_we       = req_q & we_q;
    assign mem_addr     = req_q ? {waddr_q, 2'b00} : '0;
    assign mem_wdata    = req_q ? wdata_q : 32'h0;
    assign mem_wstrb    = req_q ? mask_q : 4'b0000;

    assign stall        = ((state_q == IDLE) & req_valid) | (state_q == ISSUE);
    assign rsp_valid    = (state_q == DONE);
    assign rsp_rdata    = rdata_q;
    assign rsp_byteadd  = byteadd_q;
    assign rsp_err      = err_q;
    assign rsp_misalign = mis_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_access_ctrl
//
// Scoreboard bench for dmem_access_ctrl (TIMEOUT=4). Each access pushes its
// expected response when the request is driven. A negedge monitor pops and
// compares on every rsp_valid. The access task also checks bus signals and
// stall cycle by cycle.
// ---------------------------------------------------------------------------
module tb_dmem_access_ctrl;

    localparam int TO = 4;
    localparam int AW = 32;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_we;
    logic [1:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic [3:0]    req_mask;
    logic          stall;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_byteadd;
    logic          rsp_err;
    logic          rsp_misalign;

    dmem_access_ctrl #(.TIMEOUT(TO), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_mask     (req_mask),
        .stall        (stall),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_byteadd  (rsp_byteadd),
        .rsp_err      (rsp_err),
        .rsp_misalign (rsp_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  ba;
        logic        err;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_rsp   = 0;
    int   n_push  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Response monitor: compares every completion pulse against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid === 1'b1) begin
            n_rsp++;
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_rdata",    rsp_rdata,           e.rdata);
                chk("rsp_byteadd",  {30'd0, rsp_byteadd}, {30'd0, e.ba});
                chk("rsp_err",      {31'd0, rsp_err},     {31'd0, e.err});
                chk("rsp_misalign", {31'd0, rsp_misalign}, {31'd0, e.mis});
            end
        end
    end

    // waits = number of ISSUE cycles before the ack arrives; waits >= TO
    // means no ack is given and the access must time out.
    task automatic access(input logic we, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] mask, input int waits,
                          input logic [31:0] rdata, input logic trap);
        exp_t e;
        int   nst;
        bit   acked;
        e.ba  = addr[1:0];
        e.mis = trap;
        e.err = !trap && (waits >= TO);
        e.rdata = (trap || we || e.err) ? 32'h0 : rdata;
        sb.push_back(e);
        n_push++;
        nst = 0;

        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr;
        req_wdata = wdata; req_mask = mask; mem_ack = 1'b0;
        @(negedge clk);
        chk("accept_stall", {31'd0, stall},   32'd1);
        chk("accept_req",   {31'd0, mem_req}, 32'd0);
        if (stall === 1'b1) nst++;

        if (!trap) begin
            for (int i = 0; i < TO; i++) begin
                @(posedge clk); #1;
                req_valid = 1'b0;
                acked     = (i == waits);
                mem_ack   = acked;
                mem_rdata = acked ? rdata : $urandom;
                @(negedge clk);
                if (stall === 1'b1) nst++;
                chk("issue_req",   {31'd0, mem_req}, 32'd1);
                chk("issue_we",    {31'd0, mem_we},  {31'd0, we});
                chk("issue_addr",  mem_addr,         {addr[31:2], 2'b00});
                chk("issue_wstrb", {28'd0, mem_wstrb}, we ? {28'd0, mask} : 32'd0);
                if (we) chk("issue_wdata", mem_wdata, wdata);
                if (acked || i == TO - 1) break;
            end
        end

        @(posedge clk); #1;
        req_valid = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        chk("done_valid", {31'd0, rsp_valid}, 32'd1);
        chk("done_stall", {31'd0, stall},     32'd0);
        chk("done_req",   {31'd0, mem_req},   32'd0);
        chk("stall_cycles", nst, trap ? 32'd1 : (e.err ? 32'(1 + TO) : 32'(2 + waits)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_addr = '0; req_wdata = '0; req_mask = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req",   {31'd0, mem_req},   32'd0);
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_stall", {31'd0, stall},     32'd0);
        chk("rst_rdata", rsp_rdata,          32'd0);
        chk("rst_addr",  mem_addr,           32'd0);
        @(posedge clk); #1; rst = 1'b0;

        // Store, zero-wait bus.
        access(1'b1, 2'b10, 32'h104, 32'hDEADBEEF, 4'b1111, 0, 32'h0, 1'b0);
        // Byte load after three wait cycles.
        access(1'b0, 2'b00, 32'h20B, 32'h0, 4'b0001, 3, 32'h80112233, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold_rdata",   rsp_rdata,              32'h80112233);
        chk("hold_byteadd", {30'd0, rsp_byteadd},   32'd3);
        chk("hold_valid",   {31'd0, rsp_valid},     32'd0);

        // No ack, so the access times out.
        access(1'b0, 2'b10, 32'h300, 32'h0, 4'b1111, 99, 32'h0, 1'b0);

        // Reset in the second ISSUE cycle, followed by a late ack.
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h40;
        @(negedge clk);
        @(posedge clk); #1; req_valid = 1'b0;
        @(negedge clk);
        chk("rst_issue1_req", {31'd0, mem_req}, 32'd1);
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        chk("rst_issue2_req", {31'd0, mem_req}, 32'd1);
        @(posedge clk); #1; rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("midrst_req",   {31'd0, mem_req},   32'd0);
        chk("midrst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_stall", {31'd0, stall},     32'd0);
        chk("midrst_rdata", rsp_rdata,          32'd0);
        chk("midrst_err",   {31'd0, rsp_err},   32'd0);
        chk("midrst_addr",  mem_addr,           32'd0);
        @(posedge clk); #1; mem_ack = 1'b0;
        @(negedge clk);
        chk("lateack_valid", {31'd0, rsp_valid}, 32'd0);
        chk("lateack_req",   {31'd0, mem_req},   32'd0);

        // Spurious ack in IDLE, followed by back-to-back load and store.
        @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = 32'h0BAD0BAD;
        @(negedge clk);
        chk("spur_req",   {31'd0, mem_req},   32'd0);
        chk("spur_valid", {31'd0, rsp_valid}, 32'd0);
        chk("spur_stall", {31'd0, stall},     32'd0);
        access(1'b0, 2'b10, 32'h44, 32'h0, 4'b1111, 0, 32'h12345678, 1'b0);
        access(1'b1, 2'b01, 32'h4A, 32'hBEEF0000, 4'b1100, 1, 32'h0, 1'b0);

        // Word load at 0x102 (misaligned).
`ifdef MISALIGN_TRAP_EN
        access(1'b0, 2'b10, 32'h102, 32'h0, 4'b1111, 0, 32'h55AA55AA, 1'b1);
`else
        access(1'b0, 2'b10, 32'h102, 32'h0, 4'b1100, 0, 32'h55AA55AA, 1'b0);
`endif

        @(posedge clk); #1;
        @(negedge clk);
        chk("sb_empty",  sb.size(), 32'd0);
        chk("rsp_count", n_rsp,     n_push);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Data-memory access controller in the MEM stage, directly downstream of the store/load alignment wrapper.
- Takes the wrapper's aligned store word and byte mask and runs a single-outstanding valid/ack transaction to the data memory bus.
- Stalls the pipeline while the transaction is in flight.
- Returns the raw memory word plus the latched byte offset, which the wrapper consumes as its load input and byte address.

Parameters:
- TIMEOUT, 16, max ISSUE cycles without mem_ack before aborting with an error; 0 disables the timeout.
- AW, 32, address width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  MEM stage has a load/store.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word (11 treated as word).
- req_addr  in  AW  byte address.
- req_wdata  in  32  wrapper-aligned store data.
- req_mask  in  4  wrapper byte mask.
- stall  out  1  hold pipeline.
- mem_req  out  1  bus request, held until ack.
- mem_we  out  1  bus write.
- mem_addr  out  AW  word-aligned address ({addr[AW-1:2],2'b00}).
- mem_wdata  out  32  bus write data.
- mem_wstrb  out  4  byte strobes; 0000 on loads.
- mem_ack  in  1  bus completion.
- mem_rdata  in  32  bus read data, valid with mem_ack.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  captured read word, to wrapper load input.
- rsp_byteadd  out  2  latched req_addr[1:0], to wrapper byteadd.
- rsp_err  out  1  timeout abort, valid with rsp_valid.
- rsp_misalign  out  1  misaligned access, valid with rsp_valid.

Behaviour:
- Reset values: state IDLE, all outputs 0, counter 0.
- States: IDLE, ISSUE, DONE.
- Transitions:
  - IDLE: on req_valid, latch we, addr, wdata, mask (forced to 0000 if !req_we) and addr[1:0]; go to ISSUE.
  - ISSUE: mem_req=1 and all mem_* outputs driven from latches, stable until ack.
    - On mem_ack: capture mem_rdata if load (rsp_rdata=0 for stores); go to DONE.
    - No ack and counter==TIMEOUT-1 (TIMEOUT>0): go to DONE with err=1 and rsp_rdata=0.
    - Otherwise counter++.
  - DONE: rsp_valid=1 for exactly one cycle; req_valid ignored; go to IDLE unconditionally; counter cleared.
- mem_req is registered: it rises the cycle after acceptance and falls on the edge where ack is seen.
- stall = (IDLE & req_valid) | ISSUE, combinational. stall=0 in DONE so the pipeline advances exactly once per access.
- Latency with zero-wait memory (ack in the first ISSUE cycle):
  - accept cycle 0, mem_req cycle 1, rsp_valid cycle 2, so 2 stall cycles.
  - Each extra wait cycle adds one.
- rsp_rdata, rsp_byteadd and rsp_err hold their value after DONE until the next capture.
- mem_ack outside ISSUE is ignored (late or spurious ack).
- Reset mid-ISSUE: next edge gives IDLE with mem_req=0; a subsequent late ack is ignored and no rsp_valid is produced.
- Back-to-back accesses: the next request is accepted in the IDLE cycle following DONE. There is no overlap and never more than one outstanding transaction.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Misaligned means half with addr[1:0]==11, or word with addr[1:0]!=00.
  - A misaligned request in IDLE goes straight to DONE; mem_req is never asserted.
  - rsp_valid=1 with rsp_misalign=1, rsp_rdata=0, stall high for 1 cycle.
- Undefined:
  - rsp_misalign is tied 0.
  - Every request is issued with mem_addr word-aligned and the wrapper's mask unchanged.

Test Plan:
- Store, addr 0x104, size 10, wdata 0xDEADBEEF, mask 1111, ack in the first ISSUE cycle -> mem_addr 0x104, wstrb 1111, mem_we=1, rsp_valid in cycle 2, stall high for cycles 0-1.
- Load, addr 0x20B, size 00, ack after 3 waits with rdata 0x80112233 -> mem_wstrb 0000, rsp_rdata 0x80112233, rsp_byteadd 11, stall high for 5 cycles.
- TIMEOUT=4, no ack -> mem_req high for 4 cycles then low; rsp_valid=1 with rsp_err=1 and rsp_rdata 0.
- Reset asserted in the 2nd ISSUE cycle, then ack the next cycle -> mem_req 0 after the reset edge; no rsp_valid; all outputs 0.
- Spurious mem_ack in IDLE, then a back-to-back load and store -> the spurious ack is ignored; two rsp_valid pulses, with the second request accepted the cycle after the first DONE.
- With MISALIGN_TRAP_EN, word load at 0x102 -> no mem_req; rsp_valid and rsp_misalign the next cycle. Without the macro, the same request issues mem_addr 0x100 and rsp_misalign stays 0.
